portal_channel_mux: RTL and testbench
=====================================

# portal_channel_mux

Parametrised host-portal channel multiplexer. It terminates the single selected-channel host request/indication interface and fans it out to NREQ request FIFOs and NIND indication FIFOs, all owned inside the block. It generalises the fixed 3-request/2-indication portal top to arbitrary channel counts, data width and FIFO depth. It adds a registered interrupt channel, an interrupt mask and a saturating drop counter. It sits between the host bus adapter and user method logic.

## Interface
- WIDTH, 32: data width of every channel.
- NREQ, 3: number of request channels (1..2^SELW).
- NIND, 2: number of indication channels (1..2^SELW).
- DEPTH, 8: entries per FIFO; power of two, ≥2.
- SELW, 2: width of the select buses.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low; one clock, no other clock domains.
- request_v  in  WIDTH  host request word.
- EN_request  in  1  enqueue request_v into channel select_request.
- select_request  in  SELW  request channel index.
- RDY_request  out  1  selected request FIFO can accept.
- request_not_full  out  1  selected request FIFO not full.
- indication_data  out  WIDTH  head of selected indication FIFO.
- EN_indication  in  1  dequeue selected indication FIFO.
- select_indication  in  SELW  indication channel index.
- RDY_indication  out  1  selected indication FIFO non-empty.
- indication_not_empty  out  1  same as RDY_indication.
- ind_intr_mask  in  NIND  per-channel interrupt enable.
- ind_intr_channel  out  32  0 = no interrupt, else lowest pending channel + 1.
- drop_count  out  16  saturating count of rejected host operations.
- req_first  out  NREQ*WIDTH  head word per request FIFO; channel i at bits [i*WIDTH +: WIDTH].
- req_valid  out  NREQ  request FIFO i non-empty.
- req_deq  in  NREQ  user pops request FIFO i.
- ind_enq_v  in  NIND*WIDTH  user indication words; same packing as req_first.
- ind_enq  in  NIND  user pushes indication FIFO i.
- ind_not_full  out  NIND  indication FIFO i can accept.

## Operation
- Each FIFO is a circular buffer: DEPTH entries, rd/wr pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Head word is a combinational read of mem[rd_ptr]. Outputs are undefined-but-stable when the FIFO is empty; the bench must not check them then.
- Accepted push = push request && count<DEPTH. Accepted pop = pop request && count>0. Full/empty are judged from the registered count only: a push into a full FIFO is rejected even if a pop happens in the same cycle.
- A push and a pop in the same cycle on a FIFO that is neither full nor empty: both are accepted, count is unchanged.
- Request channel select_request<NREQ:
  - RDY_request = request_not_full = (count<DEPTH).
  - The push is EN_request.
- Request channel select_request≥NREQ (sink):
  - RDY_request=1, request_not_full=0.
  - EN_request is discarded and increments drop_count.
- EN_request on an in-range full FIFO is rejected and increments drop_count.
- Indication select_indication<NIND:
  - indication_data = head, RDY_indication = (count>0).
  - The pop is EN_indication.
- Indication select_indication≥NIND:
  - data=0, RDY_indication=0.
  - EN_indication increments drop_count.
- EN_indication on an empty in-range FIFO increments drop_count; FIFO state is unchanged.
- User req_deq on an empty FIFO and ind_enq on a full FIFO are silently ignored and are not counted.
- drop_count increments by at most 1 per cycle and saturates at 16'hFFFF.
- ind_intr_channel is a register. Next value = i+1 for the lowest i with ind count_i>0 && ind_intr_mask[i], else 0. It is computed from registered counts.

## Timing
- Reset (RST_N low, asynchronous): all counts, pointers, drop_count and ind_intr_channel are 0. req_valid=0, ind_not_full=all 1, RDY_indication=0, RDY_request=1. FIFO memory is not reset.
- A word pushed at edge k is visible at the FIFO head after edge k: one-cycle latency to req_valid / RDY_indication.
- ind_intr_channel lags the FIFO state by one further cycle (two edges after the push that made a channel pending). Unmasking a pending channel raises it on the next edge.
- Reset asserted mid-transfer: FIFO contents are lost. No output glitches beyond the asynchronous clear; first operation is allowed on the first edge after release.

## Test plan
- Reset, then host pushes 0xA0..0xA7 into request channel 1 with DEPTH=8 → after 8 edges req_valid[1]=1, RDY_request=0 (select 1). A 9th push gives drop_count=1. User pops return 0xA0..0xA7 in order.
- Full request FIFO, push and req_deq in the same cycle → push rejected, count 7, drop_count increments.
- User pushes 0x11 into indication channel 1 only, mask=2'b11 → ind_intr_channel=2 two edges later. Host selects 1 and dequeues → data 0x11, intr returns to 0 one edge after count hits 0.
- Both indication channels pending, mask=2'b10 → ind_intr_channel=2; set mask=2'b11 → 1.
- select_request=3 with NREQ=3, EN_request pulses 3 times → RDY_request=1, no FIFO changes, drop_count=3.
- Wrap-around: 20 push/pop pairs interleaved on request channel 0 → data order preserved across pointer wrap; count never exceeds 1.

Source files
------------

// File: rtl/portal_channel_mux.sv
// Host-portal channel multiplexer: one host request/indication port fanned out
// to NREQ request FIFOs and NIND indication FIFOs owned by this block, plus a
// registered interrupt channel and a saturating drop counter.

// Single circular-buffer FIFO shared by every request and indication channel.
module portalChannelFifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] enqData,
    input  logic             enq,
    input  logic             deq,
    output logic [WIDTH-1:0] first,
    output logic             notEmpty,
    output logic             notFull
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr, wrPtr;
    logic [AW:0]      count;
    logic             doEnq, doDeq;

    // Full/empty come from the registered count only, so a push into a full
    // FIFO is refused even when a pop lands in the same cycle.
    assign notFull  = (count != FULL);
    assign notEmpty = (count != '0);
    assign doEnq    = enq && notFull;
    assign doDeq    = deq && notEmpty;
    assign first    = mem[rdPtr];

    // Storage is not reset; only pointers and count are.
    always_ff @(posedge CLK) begin
        if (doEnq) mem[wrPtr] <= enqData;
    end

    // Pointer/count bookkeeping; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doEnq) wrPtr <= wrPtr + 1'b1;
            if (doDeq) rdPtr <= rdPtr + 1'b1;
            case ({doEnq, doDeq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module portal_channel_mux #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int NIND  = 2,
    parameter int DEPTH = 8,
    parameter int SELW  = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    // host request side
    input  logic [WIDTH-1:0]      request_v,
    input  logic                  EN_request,
    input  logic [SELW-1:0]       select_request,
    output logic                  RDY_request,
    output logic                  request_not_full,
    // host indication side
    output logic [WIDTH-1:0]      indication_data,
    input  logic                  EN_indication,
    input  logic [SELW-1:0]       select_indication,
    output logic                  RDY_indication,
    output logic                  indication_not_empty,
    // interrupt / status
    input  logic [NIND-1:0]       ind_intr_mask,
    output logic [31:0]           ind_intr_channel,
    output logic [15:0]           drop_count,
    // user request side
    output logic [NREQ*WIDTH-1:0] req_first,
    output logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_deq,
    // user indication side
    input  logic [NIND*WIDTH-1:0] ind_enq_v,
    input  logic [NIND-1:0]       ind_enq,
    output logic [NIND-1:0]       ind_not_full
);
    logic [NREQ-1:0][WIDTH-1:0] reqFirst;
    logic [NREQ-1:0]            reqNotEmpty, reqNotFull, reqEnq;
    logic [NIND-1:0][WIDTH-1:0] indFirst;
    logic [NIND-1:0]            indNotEmpty, indNotFull, indDeq;

    logic             reqSelHit, reqSelNotFull, reqDrop;
    logic             indSelNotEmpty, indDrop;
    logic [WIDTH-1:0] indSelData;
    logic [15:0]      dropCount;
    logic [31:0]      intrChannel, intrNext;

    // Request FIFOs: host pushes, user pops.
    for (genvar i = 0; i < NREQ; i++) begin : gReq
        portalChannelFifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uFifo (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .enqData  (request_v),
            .enq      (reqEnq[i]),
            .deq      (req_deq[i]),
            .first    (reqFirst[i]),
            .notEmpty (reqNotEmpty[i]),
            .notFull  (reqNotFull[i])
        );
    end

    // Indication FIFOs: user pushes, host pops.
    for (genvar i = 0; i < NIND; i++) begin : gInd
        portalChannelFifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uFifo (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .enqData  (ind_enq_v[i*WIDTH +: WIDTH]),
            .enq      (ind_enq[i]),
            .deq      (indDeq[i]),
            .first    (indFirst[i]),
            .notEmpty (indNotEmpty[i]),
            .notFull  (indNotFull[i])
        );
    end

    // Packed [NREQ-1:0][WIDTH-1:0] already places channel i at [i*WIDTH +: WIDTH].
    assign req_first    = reqFirst;
    assign req_valid    = reqNotEmpty;
    assign ind_not_full = indNotFull;

    // Decode the host request select; an index past NREQ is a sink that never fills.
    always_comb begin
        reqSelHit     = 1'b0;
        reqSelNotFull = 1'b0;
        reqEnq        = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (select_request == SELW'(i)) begin
                reqSelHit     = 1'b1;
                reqSelNotFull = reqNotFull[i];
                reqEnq[i]     = EN_request;
            end
        end
    end

    assign RDY_request      = reqSelHit ? reqSelNotFull : 1'b1;
    assign request_not_full = reqSelHit && reqSelNotFull;
    assign reqDrop          = EN_request && !(reqSelHit && reqSelNotFull);

    // Decode the host indication select; out-of-range reads return zero, never ready.
    always_comb begin
        indSelNotEmpty = 1'b0;
        indSelData     = '0;
        indDeq         = '0;
        for (int i = 0; i < NIND; i++) begin
            if (select_indication == SELW'(i)) begin
                indSelNotEmpty = indNotEmpty[i];
                indSelData     = indFirst[i];
                indDeq[i]      = EN_indication;
            end
        end
    end

    assign indication_data      = indSelData;
    assign RDY_indication       = indSelNotEmpty;
    assign indication_not_empty = indSelNotEmpty;
    assign indDrop              = EN_indication && !indSelNotEmpty;

    // Count rejected host operations, at most one per cycle even if both sides drop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            dropCount <= '0;
        else if ((reqDrop || indDrop) && (dropCount != 16'hFFFF))
            dropCount <= dropCount + 16'd1;
    end

    assign drop_count = dropCount;

    // Lowest pending unmasked indication channel, reported 1-based; 0 means none.
    always_comb begin
        intrNext = '0;
        for (int i = NIND - 1; i >= 0; i--) begin
            if (indNotEmpty[i] && ind_intr_mask[i]) intrNext = 32'(i + 1);
        end
    end

    // Interrupt channel is registered so it is glitch-free toward the host.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) intrChannel <= '0;
        else        intrChannel <= intrNext;
    end

    assign ind_intr_channel = intrChannel;
endmodule

// File: tb/tb_portal_channel_mux.sv
// Directed bench for portal_channel_mux with default parameters
// (WIDTH=32, NREQ=3, NIND=2, DEPTH=8, SELW=2).
module tb_portal_channel_mux;
    logic        CLK, RST_N;
    logic [31:0] request_v;
    logic        EN_request;
    logic [1:0]  select_request;
    logic        RDY_request, request_not_full;
    logic [31:0] indication_data;
    logic        EN_indication;
    logic [1:0]  select_indication;
    logic        RDY_indication, indication_not_empty;
    logic [1:0]  ind_intr_mask;
    logic [31:0] ind_intr_channel;
    logic [15:0] drop_count;
    logic [95:0] req_first;
    logic [2:0]  req_valid, req_deq;
    logic [63:0] ind_enq_v;
    logic [1:0]  ind_enq, ind_not_full;

    int nChecks = 0;
    int nFail   = 0;

    portal_channel_mux dut (
        .CLK(CLK), .RST_N(RST_N),
        .request_v(request_v), .EN_request(EN_request), .select_request(select_request),
        .RDY_request(RDY_request), .request_not_full(request_not_full),
        .indication_data(indication_data), .EN_indication(EN_indication),
        .select_indication(select_indication), .RDY_indication(RDY_indication),
        .indication_not_empty(indication_not_empty),
        .ind_intr_mask(ind_intr_mask), .ind_intr_channel(ind_intr_channel),
        .drop_count(drop_count),
        .req_first(req_first), .req_valid(req_valid), .req_deq(req_deq),
        .ind_enq_v(ind_enq_v), .ind_enq(ind_enq), .ind_not_full(ind_not_full)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  selReq;
        logic        enReq;
        logic [31:0] data;
        logic [2:0]  deq;
        logic [2:0]  expValid;
        logic        expRdy;
        logic [15:0] expDrop;
        logic        chkHead;
        logic [31:0] expHead;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] reqHead(input int ch);
        return req_first[ch*32 +: 32];
    endfunction

    initial begin
        RST_N = 1'b0;
        request_v = '0; EN_request = 1'b0; select_request = '0;
        EN_indication = 1'b0; select_indication = '0; ind_intr_mask = '0;
        req_deq = '0; ind_enq_v = '0; ind_enq = '0;

        // Request channel 1: fill, overflow, push+pop on full, drain
        for (int k = 0; k < 8; k++)
            vecs.push_back('{2'd1, 1'b1, 32'hA0 + k, 3'b000, 3'b010, (k < 7), 16'd0, 1'b1, 32'hA0});
        vecs.push_back('{2'd1, 1'b1, 32'hA8, 3'b000, 3'b010, 1'b0, 16'd1, 1'b1, 32'hA0});
        vecs.push_back('{2'd1, 1'b1, 32'hA9, 3'b010, 3'b010, 1'b1, 16'd2, 1'b1, 32'hA1});
        for (int m = 1; m <= 7; m++)
            vecs.push_back('{2'd1, 1'b0, 32'h0, 3'b010, (m < 7) ? 3'b010 : 3'b000,
                             1'b1, 16'd2, (m < 7), 32'hA1 + m});

        // Reset state
        tick(); tick();
        chk("rst req_valid", req_valid, 3'b000);
        chk("rst ind_not_full", ind_not_full, 2'b11);
        chk("rst RDY_indication", RDY_indication, 1'b0);
        chk("rst RDY_request", RDY_request, 1'b1);
        chk("rst drop_count", drop_count, 16'd0);
        chk("rst intr", ind_intr_channel, 32'd0);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            select_request = vecs[i].selReq;
            EN_request     = vecs[i].enReq;
            request_v      = vecs[i].data;
            req_deq        = vecs[i].deq;
            tick();
            chk($sformatf("vec%0d req_valid", i), req_valid, vecs[i].expValid);
            chk($sformatf("vec%0d RDY_request", i), RDY_request, vecs[i].expRdy);
            chk($sformatf("vec%0d request_not_full", i), request_not_full, vecs[i].expRdy);
            chk($sformatf("vec%0d drop_count", i), drop_count, vecs[i].expDrop);
            if (vecs[i].chkHead)
                chk($sformatf("vec%0d head", i), reqHead(int'(vecs[i].selReq)), vecs[i].expHead);
        end
        EN_request = 1'b0; req_deq = '0;

        // Single pending indication channel 1, interrupt latency and clear
        select_indication = 2'd1; ind_intr_mask = 2'b11;
        ind_enq_v = {32'h11, 32'h0}; ind_enq = 2'b10;
        tick();
        ind_enq = '0;
        chk("t3 intr edge1", ind_intr_channel, 32'd0);
        chk("t3 RDY_indication", RDY_indication, 1'b1);
        chk("t3 indication_not_empty", indication_not_empty, 1'b1);
        chk("t3 data", indication_data, 32'h11);
        tick();
        chk("t3 intr edge2", ind_intr_channel, 32'd2);
        EN_indication = 1'b1;
        tick();
        EN_indication = 1'b0;
        chk("t3 intr after deq", ind_intr_channel, 32'd2);
        chk("t3 RDY after deq", RDY_indication, 1'b0);
        tick();
        chk("t3 intr cleared", ind_intr_channel, 32'd0);
        chk("t3 drop", drop_count, 16'd2);

        // Both pending, mask selects which is reported
        ind_intr_mask = 2'b10;
        ind_enq_v = {32'h33, 32'h22}; ind_enq = 2'b11;
        tick();
        ind_enq = '0;
        tick();
        chk("t4 intr mask10", ind_intr_channel, 32'd2);
        ind_intr_mask = 2'b11;
        tick();
        chk("t4 intr mask11", ind_intr_channel, 32'd1);
        select_indication = 2'd0; #1;
        chk("t4 ch0 data", indication_data, 32'h22);
        EN_indication = 1'b1;
        tick();
        EN_indication = 1'b0;
        chk("t4 ch0 empty", RDY_indication, 1'b0);
        tick();
        chk("t4 intr ch1", ind_intr_channel, 32'd2);
        select_indication = 2'd1; #1;
        chk("t4 ch1 data", indication_data, 32'h33);
        EN_indication = 1'b1;
        tick();
        EN_indication = 1'b0;
        tick();
        chk("t4 intr none", ind_intr_channel, 32'd0);
        // Host dequeue on empty in-range channel counts as a drop
        select_indication = 2'd0; EN_indication = 1'b1;
        tick();
        EN_indication = 1'b0;
        chk("t4 empty deq drop", drop_count, 16'd3);
        // Out-of-range indication select
        select_indication = 2'd3; #1;
        chk("t4 oor data", indication_data, 32'h0);
        chk("t4 oor RDY", RDY_indication, 1'b0);
        EN_indication = 1'b1;
        tick();
        EN_indication = 1'b0;
        chk("t4 oor drop", drop_count, 16'd4);

        // User overfills indication channel 0: silently ignored
        ind_intr_mask = 2'b00;
        for (int k = 0; k < 9; k++) begin
            ind_enq_v = {32'h0, 32'h40 + k}; ind_enq = 2'b01;
            tick();
            if (k == 7) chk("ind full not_full", ind_not_full, 2'b10);
        end
        ind_enq = '0;
        chk("ind overfill not_full", ind_not_full, 2'b10);
        chk("ind overfill drop", drop_count, 16'd4);
        chk("ind masked intr", ind_intr_channel, 32'd0);
        select_indication = 2'd0; #1;
        chk("ind overfill head", indication_data, 32'h40);

        // Request sink select
        select_request = 2'd3; #1;
        chk("t5 RDY_request", RDY_request, 1'b1);
        chk("t5 request_not_full", request_not_full, 1'b0);
        for (int k = 0; k < 3; k++) begin
            request_v = 32'hEE; EN_request = 1'b1;
            tick();
        end
        EN_request = 1'b0;
        chk("t5 drop", drop_count, 16'd7);
        chk("t5 req_valid", req_valid, 3'b000);

        // Wrap-around on request channel 0
        select_request = 2'd0;
        for (int k = 0; k < 20; k++) begin
            request_v = 32'h100 + k; EN_request = 1'b1;
            tick();
            EN_request = 1'b0;
            chk($sformatf("wrap%0d valid", k), req_valid, 3'b001);
            chk($sformatf("wrap%0d head", k), reqHead(0), 32'h100 + k);
            req_deq = 3'b001;
            tick();
            req_deq = '0;
            chk($sformatf("wrap%0d empty", k), req_valid, 3'b000);
        end
        // User pop on empty request FIFO is not counted
        req_deq = 3'b001;
        tick();
        req_deq = '0;
        chk("empty req_deq drop", drop_count, 16'd7);

        // Asynchronous reset mid-transfer
        select_request = 2'd2; request_v = 32'h55; EN_request = 1'b1;
        tick();
        EN_request = 1'b0;
        chk("pre-reset valid", req_valid, 3'b100);
        #2 RST_N = 1'b0;
        #1;
        chk("async rst valid", req_valid, 3'b000);
        chk("async rst drop", drop_count, 16'd0);
        chk("async rst ind_not_full", ind_not_full, 2'b11);
        tick();
        RST_N = 1'b1;
        select_request = 2'd0; request_v = 32'h77; EN_request = 1'b1;
        tick();
        EN_request = 1'b0;
        chk("post-rst valid", req_valid, 3'b001);
        chk("post-rst head", reqHead(0), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
